// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared constants and read-tracking type for the bank arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int unsigned NUM_CLIENTS_DEF = 16;
    localparam int unsigned DATA_W_DEF      = 256;
    localparam int unsigned BANK_ADDR_W_DEF = 10;
    localparam int unsigned CLIENT_ID_W_DEF = $clog2(NUM_CLIENTS_DEF);

    typedef struct packed {
        logic                       valid;
        logic [CLIENT_ID_W_DEF-1:0] id;
    } rd_track_s;

endpackage

`default_nettype wire

// File: rtl/mem_bank_arb_if.sv
// ============================================================================
// Module      : mem_bank_arb_if
// Description : Client request column plus SRAM port of one bank arbiter.
//               The lock vector exists only when MEM_ARB_LOCK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_bank_arb_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = NUM_CLIENTS_DEF,
    parameter int unsigned ADDR_W      = BANK_ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF
);

    logic [NUM_CLIENTS-1:0]             req;
    logic [NUM_CLIENTS-1:0]             we;
    logic [NUM_CLIENTS-1:0][ADDR_W-1:0] addr;
    logic [NUM_CLIENTS-1:0][DATA_W-1:0] wdata;
    logic [NUM_CLIENTS-1:0][DATA_W-1:0] wmask;
`ifdef MEM_ARB_LOCK_EN
    logic [NUM_CLIENTS-1:0]             lock;
`endif
    logic [NUM_CLIENTS-1:0]             gnt;
    logic [NUM_CLIENTS-1:0]             rvalid;
    logic [DATA_W-1:0]                  rdata;

    logic                               sram_cs;
    logic                               sram_we;
    logic [ADDR_W-1:0]                  sram_addr;
    logic [DATA_W-1:0]                  sram_wdata;
    logic [DATA_W-1:0]                  sram_wmask;
    logic [DATA_W-1:0]                  sram_rdata;

`ifdef MEM_ARB_LOCK_EN
    modport master (
        output req, we, addr, wdata, wmask, lock, sram_rdata,
        input  gnt, rvalid, rdata, sram_cs, sram_we, sram_addr, sram_wdata, sram_wmask
    );
    modport slave (
        input  req, we, addr, wdata, wmask, lock, sram_rdata,
        output gnt, rvalid, rdata, sram_cs, sram_we, sram_addr, sram_wdata, sram_wmask
    );
`else
    modport master (
        output req, we, addr, wdata, wmask, sram_rdata,
        input  gnt, rvalid, rdata, sram_cs, sram_we, sram_addr, sram_wdata, sram_wmask
    );
    modport slave (
        input  req, we, addr, wdata, wmask, sram_rdata,
        output gnt, rvalid, rdata, sram_cs, sram_we, sram_addr, sram_wdata, sram_wmask
    );
`endif

endinterface

`default_nettype wire

// File: rtl/mem_bank_arb_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin pick: first set request at or
//               above i_ptr, wrapping at NUM_CLIENTS-1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int unsigned NUM_CLIENTS = 16,
    parameter int unsigned ID_W        = 4
) (
    input  logic [NUM_CLIENTS-1:0] i_req,
    input  logic [ID_W-1:0]        i_ptr,
    output logic [NUM_CLIENTS-1:0] o_gnt,
    output logic [ID_W-1:0]        o_idx,
    output logic                   o_any
);

    function automatic logic [ID_W-1:0] wrap_idx(input int v);
        return (v >= int'(NUM_CLIENTS)) ? ID_W'(v - int'(NUM_CLIENTS)) : ID_W'(v);
    endfunction

    // Scan offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int k = int'(NUM_CLIENTS) - 1; k >= 0; k--) begin
            if (i_req[wrap_idx(int'(i_ptr) + k)]) begin
                o_idx = wrap_idx(int'(i_ptr) + k);
                o_any = 1'b1;
            end
        end
        o_gnt = o_any ? (NUM_CLIENTS'(1) << o_idx) : '0;
    end

endmodule

`default_nettype wire

// File: rtl/mem_bank_arb.sv
// ============================================================================
// Module      : mem_bank_arb
// Description : Round-robin arbiter sharing one SRAM bank among NUM_CLIENTS,
//               with in-order read return. MEM_ARB_LOCK_EN adds grant locking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bank_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = NUM_CLIENTS_DEF,
    parameter int unsigned ADDR_W      = BANK_ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned LOCK_MAX    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_bank_arb_if.slave bus
);

    localparam int unsigned c_ID_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("mem_bank_arb: RD_LAT must be 1..4");
    end
    if (NUM_CLIENTS > (1 << CLIENT_ID_W_DEF) || LOCK_MAX < 1) begin : g_bad_cfg
        $error("mem_bank_arb: NUM_CLIENTS exceeds tracked id width or LOCK_MAX < 1");
    end

    function automatic logic [c_ID_W-1:0] next_id(input logic [c_ID_W-1:0] id);
        return (int'(id) == int'(NUM_CLIENTS) - 1) ? '0 : id + c_ID_W'(1);
    endfunction

    logic [NUM_CLIENTS-1:0] w_pick_gnt;
    logic [c_ID_W-1:0]      w_pick_idx;
    logic                   w_pick_any;
    logic [c_ID_W-1:0]      r_rr_ptr;
    logic [c_ID_W-1:0]      w_rr_ptr_nxt;
    logic [c_ID_W-1:0]      w_win;
    logic                   w_any;
    logic                   w_wr;
    logic                   w_rd_push;
    rd_track_s              r_pipe [RD_LAT];
    rd_track_s              w_pipe_out;
    logic [DATA_W-1:0]      r_rdata_hold;
    logic [DATA_W-1:0]      w_rdata;

    rr_pick #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .ID_W        (c_ID_W)
    ) u_rr_pick (
        .i_req (bus.req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

`ifdef MEM_ARB_LOCK_EN
    localparam int unsigned c_CNT_W = $clog2(LOCK_MAX + 1);

    logic                r_lock_act;
    logic                w_lock_act_nxt;
    logic [c_ID_W-1:0]   r_lock_owner;
    logic [c_ID_W-1:0]   w_lock_owner_nxt;
    logic [c_CNT_W-1:0]  r_lock_cnt;
    logic [c_CNT_W-1:0]  w_lock_cnt_nxt;
    logic                w_hold;

    // The owner keeps the bank only while it still requests with lock raised.
    assign w_hold  = r_lock_act & bus.req[r_lock_owner] & bus.lock[r_lock_owner];
    assign w_win   = w_hold ? r_lock_owner : w_pick_idx;
    assign w_any   = rst_n & (w_hold | w_pick_any);
    assign bus.gnt = !rst_n ? '0 : (w_hold ? (NUM_CLIENTS'(1) << r_lock_owner) : w_pick_gnt);

    always_comb begin
        w_rr_ptr_nxt     = r_rr_ptr;
        w_lock_act_nxt   = 1'b0;
        w_lock_owner_nxt = r_lock_owner;
        w_lock_cnt_nxt   = '0;
        if (w_hold) begin
            if (int'(r_lock_cnt) + 1 >= int'(LOCK_MAX)) begin
                w_rr_ptr_nxt = next_id(r_lock_owner);
            end else begin
                w_lock_act_nxt = 1'b1;
                w_lock_cnt_nxt = r_lock_cnt + c_CNT_W'(1);
            end
        end else if (w_any) begin
            if (bus.lock[w_win] && LOCK_MAX > 1) begin
                w_lock_act_nxt   = 1'b1;
                w_lock_owner_nxt = w_win;
                w_lock_cnt_nxt   = c_CNT_W'(1);
            end else begin
                w_rr_ptr_nxt = next_id(w_win);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_act   <= 1'b0;
            r_lock_owner <= '0;
            r_lock_cnt   <= '0;
        end else begin
            r_lock_act   <= w_lock_act_nxt;
            r_lock_owner <= w_lock_owner_nxt;
            r_lock_cnt   <= w_lock_cnt_nxt;
        end
    end
`else
    assign w_win        = w_pick_idx;
    assign w_any        = rst_n & w_pick_any;
    assign bus.gnt      = rst_n ? w_pick_gnt : '0;
    assign w_rr_ptr_nxt = w_any ? next_id(w_win) : r_rr_ptr;
`endif

    // Reads drive zero write data/mask so the SRAM never sees stale operands.
    assign w_wr           = w_any & bus.we[w_win];
    assign w_rd_push      = w_any & ~bus.we[w_win];
    assign bus.sram_cs    = w_any;
    assign bus.sram_we    = w_wr;
    assign bus.sram_addr  = w_any ? bus.addr[w_win]  : '0;
    assign bus.sram_wdata = w_wr  ? bus.wdata[w_win] : '0;
    assign bus.sram_wmask = w_wr  ? bus.wmask[w_win] : '0;

    assign w_pipe_out = r_pipe[RD_LAT-1];
    assign w_rdata    = w_pipe_out.valid ? bus.sram_rdata : r_rdata_hold;
    assign bus.rdata  = w_rdata;
    assign bus.rvalid = w_pipe_out.valid ? (NUM_CLIENTS'(1) << w_pipe_out.id) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_rdata_hold <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                r_pipe[i] <= '{valid: 1'b0, id: '0};
            end
        end else begin
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_rdata_hold <= w_rdata;
            r_pipe[0]    <= '{valid: w_rd_push, id: CLIENT_ID_W_DEF'(w_win)};
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_bank_arb.sv
// ============================================================================
// Module      : tb_mem_bank_arb
// Description : Self-checking bench; runs RD_LAT=1 and RD_LAT=3 instances on
//               shared stimulus against a behavioural arbitration model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bank_arb;

    localparam int NC = 16;
    localparam int AW = 10;
    localparam int DW = 256;

    typedef struct {
        int due;
        int id;
    } ret_t;

    logic clk;
    logic rst_n;

    logic [NC-1:0]         tb_req;
    logic [NC-1:0]         tb_we;
    logic [NC-1:0][AW-1:0] tb_addr;
    logic [NC-1:0][DW-1:0] tb_wdata;
    logic [NC-1:0][DW-1:0] tb_wmask;
    logic [NC-1:0]         tb_lock;
    logic [DW-1:0]         tb_srd;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int m_ptr   = 0;
    int m_win   = -1;
    ret_t rq0[$];
    ret_t rq1[$];
    logic [DW-1:0] last_rd [2];

    logic [NC-1:0] e_gnt;
    logic          e_cs;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [DW-1:0] e_wm;

    logic [NC-1:0] obs_gnt;
    logic          obs_cs;
    logic [AW-1:0] obs_addr;
    logic [NC-1:0] obs_rv1;
    logic [NC-1:0] obs_rv3;
    logic [DW-1:0] obs_rd1;
    logic [DW-1:0] obs_rd3;
    int            tally [NC];

    mem_bank_arb_if #(.NUM_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW)) bus1 ();
    mem_bank_arb_if #(.NUM_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW)) bus3 ();

    assign bus1.req = tb_req;    assign bus3.req = tb_req;
    assign bus1.we = tb_we;      assign bus3.we = tb_we;
    assign bus1.addr = tb_addr;  assign bus3.addr = tb_addr;
    assign bus1.wdata = tb_wdata; assign bus3.wdata = tb_wdata;
    assign bus1.wmask = tb_wmask; assign bus3.wmask = tb_wmask;
    assign bus1.sram_rdata = tb_srd; assign bus3.sram_rdata = tb_srd;
`ifdef MEM_ARB_LOCK_EN
    assign bus1.lock = tb_lock;  assign bus3.lock = tb_lock;
`endif

    mem_bank_arb #(.NUM_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .LOCK_MAX(2))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    mem_bank_arb #(.NUM_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .LOCK_MAX(2))
        u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string p);
        chk({p, " gnt1"}, DW'(bus1.gnt), '0);       chk({p, " gnt3"}, DW'(bus3.gnt), '0);
        chk({p, " cs1"}, DW'(bus1.sram_cs), '0);    chk({p, " cs3"}, DW'(bus3.sram_cs), '0);
        chk({p, " we1"}, DW'(bus1.sram_we), '0);    chk({p, " we3"}, DW'(bus3.sram_we), '0);
        chk({p, " addr1"}, DW'(bus1.sram_addr), '0);
        chk({p, " wdata1"}, bus1.sram_wdata, '0);   chk({p, " wmask1"}, bus1.sram_wmask, '0);
        chk({p, " rvalid1"}, DW'(bus1.rvalid), '0); chk({p, " rvalid3"}, DW'(bus3.rvalid), '0);
        chk({p, " rdata1"}, bus1.rdata, '0);        chk({p, " rdata3"}, bus3.rdata, '0);
    endtask

    task automatic chk_dut(input int d, input logic [NC-1:0] g, input logic cs, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [DW-1:0] wm,
                           input logic [NC-1:0] rv, input logic [DW-1:0] rd);
        string p = (d == 0) ? "lat1" : "lat3";
        logic [NC-1:0] erv = '0;
        logic [DW-1:0] erd;
        ret_t head;
        chk({p, " gnt"}, DW'(g), DW'(e_gnt));
        chk({p, " sram_cs"}, DW'(cs), DW'(e_cs));
        chk({p, " sram_we"}, DW'(we), DW'(e_we));
        if (e_cs) begin
            chk({p, " sram_addr"}, DW'(a), DW'(e_addr));
            chk({p, " sram_wdata"}, wd, e_wd);
            chk({p, " sram_wmask"}, wm, e_wm);
        end
        erd = last_rd[d];
        if (d == 0) begin
            if (rq0.size() > 0 && rq0[0].due == cyc) begin
                head = rq0.pop_front(); erv = NC'(1) << head.id; erd = tb_srd;
            end
        end else begin
            if (rq1.size() > 0 && rq1[0].due == cyc) begin
                head = rq1.pop_front(); erv = NC'(1) << head.id; erd = tb_srd;
            end
        end
        last_rd[d] = erd;
        chk({p, " rvalid"}, DW'(rv), DW'(erv));
        chk({p, " rdata"}, rd, erd);
    endtask

    // One clock cycle: called at a falling edge with inputs already applied.
    task automatic step(input bit use_model);
        int win;
        tb_srd = rand256();
        #1;
        obs_gnt = bus1.gnt;  obs_cs = bus1.sram_cs;  obs_addr = bus1.sram_addr;
        obs_rv1 = bus1.rvalid; obs_rd1 = bus1.rdata;
        obs_rv3 = bus3.rvalid; obs_rd3 = bus3.rdata;
        if (use_model) begin
            win = -1;
            for (int i = 0; i < NC; i++)
                if (win < 0 && tb_req[(m_ptr + i) % NC]) win = (m_ptr + i) % NC;
            e_cs   = (win >= 0);
            e_gnt  = e_cs ? (NC'(1) << win) : '0;
            e_we   = e_cs ? tb_we[win] : 1'b0;
            e_addr = e_cs ? tb_addr[win] : '0;
            e_wd   = (e_cs && e_we) ? tb_wdata[win] : '0;
            e_wm   = (e_cs && e_we) ? tb_wmask[win] : '0;
            chk_dut(0, bus1.gnt, bus1.sram_cs, bus1.sram_we, bus1.sram_addr, bus1.sram_wdata,
                    bus1.sram_wmask, bus1.rvalid, bus1.rdata);
            chk_dut(1, bus3.gnt, bus3.sram_cs, bus3.sram_we, bus3.sram_addr, bus3.sram_wdata,
                    bus3.sram_wmask, bus3.rvalid, bus3.rdata);
            if (e_cs) begin
                m_ptr = (win + 1) % NC;
                if (!e_we) begin
                    rq0.push_back('{due: cyc + 1, id: win});
                    rq1.push_back('{due: cyc + 3, id: win});
                end
            end
            m_win = win;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic model_reset();
        rq0.delete(); rq1.delete();
        last_rd[0] = '0; last_rd[1] = '0;
        m_ptr = 0; m_win = -1;
    endtask

    initial begin
        rst_n = 1'b0;
        tb_req = 16'h0001; tb_we = '0; tb_addr = '0; tb_wdata = '0; tb_wmask = '0;
        tb_lock = '0; tb_srd = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single read from client 0
        tb_req = 16'h0001; tb_we = '0; tb_addr[0] = 10'h055;
        step(1);
        chk("t1 gnt", DW'(obs_gnt), DW'(16'h0001));
        chk("t1 cs", DW'(obs_cs), DW'(1'b1));
        chk("t1 addr", DW'(obs_addr), DW'(10'h055));
        tb_req = '0;
        step(1);
        chk("t1 rvalid", DW'(obs_rv1), DW'(16'h0001));
        chk("t1 rdata", obs_rd1, tb_srd);

        // Everyone requesting for two full rounds
        for (int i = 0; i < NC; i++) tally[i] = 0;
        tb_req = '1;
        for (int n = 0; n < 2 * NC; n++) begin
            if (m_win >= 0) begin
                tb_we[m_win] = 1'($urandom_range(0, 1));
                tb_addr[m_win] = AW'($urandom());
                tb_wdata[m_win] = rand256(); tb_wmask[m_win] = rand256();
            end
            step(1);
            for (int i = 0; i < NC; i++) if (obs_gnt[i]) tally[i]++;
        end
        for (int i = 0; i < NC; i++) chk($sformatf("fair client%0d", i), DW'(tally[i]), DW'(2));

        // Pointer placement: after client 5, client 7 beats client 3
        tb_req = 16'h0020; tb_we = '0;
        step(1);
        tb_req = 16'h0088;
        step(1);
        chk("ptr first", DW'(obs_gnt), DW'(16'h0080));
        tb_req = 16'h0008;
        step(1);
        chk("ptr second", DW'(obs_gnt), DW'(16'h0008));

        // Back-to-back reads, 3-cycle latency instance
        tb_req = '0;
        repeat (4) step(1);
        tb_we = '0;
        tb_req = 16'h0004; step(1);
        tb_req = 16'h0200; step(1);
        tb_req = 16'h0010; step(1);
        tb_req = '0;
        step(1);
        chk("lat3 ret a", DW'(obs_rv3), DW'(16'h0004)); chk("lat3 data a", obs_rd3, tb_srd);
        step(1);
        chk("lat3 ret b", DW'(obs_rv3), DW'(16'h0200)); chk("lat3 data b", obs_rd3, tb_srd);
        step(1);
        chk("lat3 ret c", DW'(obs_rv3), DW'(16'h0010)); chk("lat3 data c", obs_rd3, tb_srd);

        // Randomised traffic; each client holds its request until granted
        m_win = -1;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NC; i++) begin
                if (!tb_req[i] || i == m_win) begin
                    tb_req[i] = ($urandom_range(0, 2) != 0);
                    tb_we[i] = 1'($urandom_range(0, 1));
                    tb_addr[i] = AW'($urandom());
                    tb_wdata[i] = rand256(); tb_wmask[i] = rand256();
                end
            end
            step(1);
        end

        // Reset with a read in flight
        tb_req = '0;
        repeat (4) step(1);
        tb_req = 16'h0002; tb_we = '0;
        step(1);
        chk("mid gnt", DW'(obs_gnt), DW'(16'h0002));
        rst_n = 1'b0;
        #1 chk_zero("midrst");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) step(1);

`ifdef MEM_ARB_LOCK_EN
        // Locked two-beat access from client 4 with client 5 waiting
        tb_req = 16'h0008; tb_we = '1;
        step(1);
        tb_req = 16'h0030; tb_lock = 16'h0010;
        step(0);
        chk("lock beat0", DW'(obs_gnt), DW'(16'h0010));
        step(0);
        chk("lock beat1", DW'(obs_gnt), DW'(16'h0010));
        step(0);
        chk("lock release", DW'(obs_gnt), DW'(16'h0020));
        tb_req = '0; tb_lock = '0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
